// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sequencer
//  Purpose  : Alternates exposure windows with full-frame readouts and
//             handshakes with the readout engine, with a readout watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [31:0]      t_exp,
    input  logic [31:0]      t_gap,
    input  logic [31:0]      t_timeout,
    input  logic             re_busy,
    output logic             ro_trigger,
    output logic             expose,
    output logic             seq_busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXPOSE  = 3'd1,
        ST_RO_REQ  = 3'd2,
        ST_RO_WAIT = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [31:0]            tmr_q, tmr_d;
    logic [31:0]            len_q, len_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       num_q, num_d;
    logic                   stop_q, stop_d;
    logic                   terr_q, terr_d;

    logic                   rb_s;
    logic                   tmr_last;
    logic                   wd_expire;
    logic [31:0]            exp_len;
    logic [31:0]            tmr_inc;
    logic [CNT_W-1:0]       cnt_inc;

    assign rb_s      = sync_q[SYNC_STAGES-1];
    assign exp_len   = (t_exp == 32'd0) ? 32'd1 : t_exp;
    // Widened compares so a target of all-ones can never wrap the timer.
    assign tmr_last  = ({1'b0, tmr_q} + 33'd1) >= {1'b0, len_q};
    assign wd_expire = (t_timeout != 32'd0) &&
                       (({1'b0, tmr_q} + 33'd1) >= {1'b0, t_timeout});
    assign tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + 32'd1;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], re_busy};
        tmr_d      = tmr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        stop_d     = stop_q;
        terr_d     = terr_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (continuous || (num_frames != '0))) begin
                    state_d = ST_EXPOSE;
                    tmr_d   = '0;
                    len_d   = exp_len;
                    cnt_d   = '0;
                    num_d   = num_frames;
                    stop_d  = 1'b0;
                    terr_d  = 1'b0;
                end
            end
            ST_EXPOSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tmr_last) begin
                    state_d = ST_RO_REQ;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ST_RO_REQ: begin
                if (stop) stop_d = 1'b1;
                // A handshake seen in the expiry cycle still counts.
                if (rb_s) begin
                    state_d = ST_RO_WAIT;
                    tmr_d   = '0;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ST_RO_WAIT: begin
                if (stop) stop_d = 1'b1;
                if (!rb_s) begin
                    frame_done = 1'b1;
                    cnt_d      = cnt_inc;
                    tmr_d      = '0;
                    if (stop || stop_q || (!continuous && (cnt_inc == num_q))) begin
                        state_d = ST_IDLE;
                    end else if (t_gap != 32'd0) begin
                        state_d = ST_GAP;
                        len_d   = t_gap;
                    end else begin
                        state_d = ST_EXPOSE;
                        len_d   = exp_len;
                    end
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tmr_last) begin
                    state_d = ST_EXPOSE;
                    tmr_d   = '0;
                    len_d   = exp_len;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sync_q  <= '0;
            tmr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            stop_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tmr_q   <= tmr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            stop_q  <= stop_d;
            terr_q  <= terr_d;
        end
    end

    // Gates decode straight from the state flop so reset clears them at once.
    assign expose      = (state_q == ST_EXPOSE);
    assign ro_trigger  = (state_q == ST_RO_REQ);
    assign seq_busy    = (state_q != ST_IDLE);
    assign frame_cnt   = cnt_q;
    assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_sequencer
//  Purpose  : Scoreboard bench for frame_sequencer with a readout-engine model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_sequencer;

    logic        CLK;
    logic        rst;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] num_frames;
    logic [31:0] t_exp;
    logic [31:0] t_gap;
    logic [31:0] t_timeout;
    logic        re_busy;
    logic        ro_trigger;
    logic        expose;
    logic        seq_busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;
    logic model_en;

    // Expected expose run lengths, trigger run lengths, frame_cnt after each
    // frame_done, and idle cycles between frame_done and the next exposure.
    int exp_q[$];
    int trig_q[$];
    int fd_q[$];
    int gap_q[$];

    frame_sequencer #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .num_frames (num_frames),
        .t_exp      (t_exp),
        .t_gap      (t_gap),
        .t_timeout  (t_timeout),
        .re_busy    (re_busy),
        .ro_trigger (ro_trigger),
        .expose     (expose),
        .seq_busy   (seq_busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .timeout_err(timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic int probe(input int sel);
        case (sel)
            0:       return int'(ro_trigger);
            1:       return int'(seq_busy);
            2:       return int'(frame_cnt);
            default: return int'(expose);
        endcase
    endfunction

    task automatic wait_for(input int sel, input int val, input int budget, input string nm);
        int n = 0;
        while (probe(sel) != val && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (probe(sel) != val) begin
            tests++;
            fails++;
            $display("FAIL wait_%s: got %0d after %0d cycles, required %0d", nm, probe(sel), budget, val);
        end
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Readout engine: busy rises 3 cycles after trigger and holds 20 cycles.
    initial begin
        re_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (model_en && ro_trigger && !rst) begin
                repeat (3) @(posedge CLK);
                #1 re_busy = 1'b1;
                repeat (20) @(posedge CLK);
                #1 re_busy = 1'b0;
            end
        end
    end

    // Monitor
    int exp_run = 0;
    int trig_run = 0;
    int gap_run = 0;
    bit fd_pend = 1'b0;
    bit gap_arm = 1'b0;

    always @(negedge CLK) begin
        if (rst) begin
            exp_run = 0; trig_run = 0; gap_run = 0;
            fd_pend = 1'b0; gap_arm = 1'b0;
        end else begin
            if (expose) exp_run++;
            else if (exp_run > 0) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL expose_len: got unexpected run of %0d, required none", exp_run);
                end else check("expose_len", exp_run, exp_q.pop_front());
                exp_run = 0;
            end

            if (ro_trigger) trig_run++;
            else if (trig_run > 0) begin
                if (trig_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL trigger_len: got unexpected run of %0d, required none", trig_run);
                end else check("trigger_len", trig_run, trig_q.pop_front());
                trig_run = 0;
            end

            if (fd_pend) begin
                if (fd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_done: got unexpected pulse (cnt %0d), required none", frame_cnt);
                end else check("frame_cnt_after_done", frame_cnt, fd_q.pop_front());
                fd_pend = 1'b0;
            end

            if (frame_done) begin
                fd_pend = 1'b1;
                gap_arm = 1'b1;
                gap_run = 0;
            end else if (gap_arm) begin
                if (expose) begin
                    if (gap_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL gap_len: got unexpected gap of %0d, required none", gap_run);
                    end else check("gap_len", gap_run, gap_q.pop_front());
                    gap_arm = 1'b0;
                end else if (!seq_busy) gap_arm = 1'b0;
                else gap_run++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish within 500us");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        num_frames = '0; t_exp = '0; t_gap = '0; t_timeout = '0; model_en = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ro_trigger", ro_trigger, 0);
        check("rst_expose", expose, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge CLK); #1 rst = 1'b0;

        // Single frame
        num_frames = 16'd1; t_exp = 32'd10; t_gap = 32'd5;
        exp_q.push_back(10); trig_q.push_back(6); fd_q.push_back(1);
        pulse_start();
        wait_for(1, 0, 200, "single_done");
        check("single_frame_cnt", frame_cnt, 1);
        idle(3);

        // Multi-frame with gaps
        num_frames = 16'd3; t_exp = 32'd5; t_gap = 32'd4;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5); trig_q.push_back(6); fd_q.push_back(i + 1);
            if (i < 2) gap_q.push_back(4);
        end
        pulse_start();
        wait_for(1, 0, 400, "multi_done");
        check("multi_frame_cnt", frame_cnt, 3);
        idle(3);

        // Continuous, zero gap, zero exposure, stop in the 6th RO_WAIT
        continuous = 1'b1; num_frames = 16'd0; t_exp = 32'd0; t_gap = 32'd0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(1); trig_q.push_back(6); fd_q.push_back(i + 1);
            if (i < 5) gap_q.push_back(0);
        end
        pulse_start();
        wait_for(2, 5, 600, "cont_five");
        wait_for(0, 1, 50, "cont_trig_hi");
        wait_for(0, 0, 50, "cont_trig_lo");
        @(posedge CLK); #1 stop = 1'b1;
        @(posedge CLK); #1 stop = 1'b0;
        wait_for(1, 0, 200, "cont_done");
        check("cont_frame_cnt", frame_cnt, 6);
        continuous = 1'b0;
        idle(3);

        // Stop during exposure, in exposure cycle 20
        num_frames = 16'd1; t_exp = 32'd100;
        exp_q.push_back(20);
        pulse_start();
        repeat (19) @(posedge CLK);
        #1 stop = 1'b1;
        @(posedge CLK); #1 stop = 1'b0;
        @(negedge CLK);
        check("stop_exp_seq_busy", seq_busy, 0);
        check("stop_exp_expose", expose, 0);
        check("stop_exp_frame_cnt", frame_cnt, 0);
        idle(5);
        check("stop_exp_no_trigger", ro_trigger, 0);

        // Watchdog
        model_en = 1'b0; t_timeout = 32'd50; t_exp = 32'd3; num_frames = 16'd1;
        exp_q.push_back(3); trig_q.push_back(50);
        pulse_start();
        wait_for(1, 0, 200, "wd_idle");
        check("wd_timeout_err", timeout_err, 1);
        check("wd_frame_cnt", frame_cnt, 0);
        idle(5);
        check("wd_sticky", timeout_err, 1);
        model_en = 1'b1;
        exp_q.push_back(3); trig_q.push_back(6); fd_q.push_back(1);
        pulse_start();
        @(negedge CLK);
        check("wd_clear_on_start", timeout_err, 0);
        check("wd_restart_busy", seq_busy, 1);
        wait_for(1, 0, 200, "wd_restart_done");
        check("wd_no_false_expire", timeout_err, 0);
        check("wd_restart_cnt", frame_cnt, 1);
        idle(3);

        // Asynchronous reset while in RO_REQ of frame 2
        t_timeout = 32'd0; num_frames = 16'd2; t_exp = 32'd3; t_gap = 32'd2;
        exp_q.push_back(3); exp_q.push_back(3); trig_q.push_back(6);
        fd_q.push_back(1); gap_q.push_back(2);
        pulse_start();
        wait_for(2, 1, 200, "rst_test_first");
        model_en = 1'b0;
        wait_for(0, 1, 50, "rst_test_trig");
        @(posedge CLK); #3 rst = 1'b1;
        #1;
        check("async_rst_ro_trigger", ro_trigger, 0);
        check("async_rst_expose", expose, 0);
        check("async_rst_seq_busy", seq_busy, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        @(posedge CLK); #1 rst = 1'b0;
        model_en = 1'b1;
        idle(3);

        // Start ignored with zero frame count
        num_frames = 16'd0; continuous = 1'b0;
        pulse_start();
        @(negedge CLK);
        check("ignore_start_busy", seq_busy, 0);
        idle(4);
        check("ignore_start_busy_later", seq_busy, 0);

        // Start and stop together in IDLE: start wins, stop not latched
        num_frames = 16'd2; t_exp = 32'd2; t_gap = 32'd1;
        exp_q.push_back(2); exp_q.push_back(2);
        trig_q.push_back(6); trig_q.push_back(6);
        fd_q.push_back(1); fd_q.push_back(2); gap_q.push_back(1);
        @(posedge CLK); #1 start = 1'b1; stop = 1'b1;
        @(posedge CLK); #1 start = 1'b0; stop = 1'b0;
        @(negedge CLK);
        check("start_stop_busy", seq_busy, 1);
        wait_for(1, 0, 300, "start_stop_done");
        check("start_stop_frame_cnt", frame_cnt, 2);
        idle(4);

        check("sb_expose_left", exp_q.size(), 0);
        check("sb_trigger_left", trig_q.size(), 0);
        check("sb_frame_done_left", fd_q.size(), 0);
        check("sb_gap_left", gap_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
